// File: rtl/bbf_int_to_double_seq_if.sv
// Operand/result handshake bundle for the int64 -> binary64 converter.
//
// Signals:
//   in          64  signed integer operand, two's complement
//   in_valid     1  operand valid
//   in_ready     1  converter can accept an operand
//   out         64  binary64 result bits {sign, exp[10:0], frac[51:0]}
//   out_inexact  1  result differs from the exact integer value
//   out_valid    1  result valid
//   out_ready    1  consumer accepts the result
//
// Modports:
//   master  producer/consumer side (drives operand and out_ready)
//   slave   converter side (drives in_ready and the result)
interface bbf_int_to_double_seq_if;
    logic [63:0] in;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out;
    logic        out_inexact;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out,
        input  out_inexact,
        input  out_valid
    );

    modport slave (
        input  in,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out,
        output out_inexact,
        output out_valid
    );
endinterface

// File: rtl/bbf_int_to_double_seq.sv
// Multi-cycle converter from a signed 64-bit integer to an IEEE-754 binary64
// bit pattern, rounded to nearest, ties to even.
//
// The operand magnitude is normalized iteratively (one shift per cycle,
// STEP bits at a time when the top STEP bits are all zero), then rounded in
// a single cycle and held until the consumer takes it.
//
// Parameters:
//   STEP   coarse normalization shift distance, legal range 1..8
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous reset, active low (asserted when 0)
//   bus    slave side of bbf_int_to_double_seq_if (operand in, result out)
module bbf_int_to_double_seq #(
    parameter int STEP = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    bbf_int_to_double_seq_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] NORM  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Biased exponent of a value whose leading one sits at bit 63: 1023 + 63.
    localparam logic [10:0] EXP_TOP = 11'd1086;

    logic [1:0]  state;
    logic        sign;
    logic [63:0] mag;
    logic [10:0] exp_q;
    logic [63:0] result;
    logic        inexact;

    logic [63:0] in_mag;
    logic        coarse_ok;
    logic [51:0] frac_trunc;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [52:0] frac_sum;
    logic [10:0] exp_rnd;

    // Operand magnitude, coarse-shift eligibility and the rounding datapath.
    // The magnitude of -2^63 wraps to 0x8000000000000000, which is exactly
    // the unsigned value we want. A carry out of the 52-bit fraction leaves
    // the fraction at zero and bumps the exponent; since the largest exponent
    // reachable is 1086 this can never overflow into infinity.
    always_comb begin
        in_mag     = bus.in[63] ? (~bus.in + 64'd1) : bus.in;
        coarse_ok  = (mag[63 -: STEP] == '0);
        frac_trunc = mag[62:11];
        guard      = mag[10];
        sticky     = |mag[9:0];
        round_up   = guard & (sticky | frac_trunc[0]);
        frac_sum   = {1'b0, frac_trunc} + {52'd0, round_up};
        exp_rnd    = exp_q + {10'd0, frac_sum[52]};
    end

    // Handshake outputs follow the state; reset masks everything so the
    // outputs read zero for as long as reset is held.
    assign bus.in_ready    = reset && (state == IDLE);
    assign bus.out_valid   = reset && (state == DONE);
    assign bus.out         = reset ? result : 64'd0;
    assign bus.out_inexact = reset && inexact;

    // Control and datapath registers. A zero operand skips normalization
    // and rounding entirely and produces +0.0, so negative zero never
    // appears. DONE returns to IDLE on the handshake edge, so the next
    // operand can only be taken one cycle after a result is consumed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            sign    <= 1'b0;
            mag     <= 64'd0;
            exp_q   <= 11'd0;
            result  <= 64'd0;
            inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign  <= bus.in[63];
                        mag   <= in_mag;
                        exp_q <= EXP_TOP;
                        if (in_mag == 64'd0) begin
                            result  <= 64'd0;
                            inexact <= 1'b0;
                            state   <= DONE;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mag[63]) begin
                        state <= ROUND;
                    end else if (coarse_ok) begin
                        mag   <= mag << STEP;
                        exp_q <= exp_q - 11'(STEP);
                    end else begin
                        mag   <= mag << 1;
                        exp_q <= exp_q - 11'd1;
                    end
                end
                ROUND: begin
                    result  <= {sign, exp_rnd, frac_sum[51:0]};
                    inexact <= guard | sticky;
                    state   <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bbf_int_to_double_seq.sv
// Self-checking bench for bbf_int_to_double_seq.
//
// Two converters (STEP=1 and STEP=8) share one stimulus source; use_step1
// selects which one is observed. Directed operands check exact results,
// latency, backpressure and mid-operation reset; randomized operands with
// random handshakes are scored in order against an arithmetic reference.
module tb_bbf_int_to_double_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic        in_valid;
    logic        out_ready;
    bit          use_step1;

    int checks;
    int failures;

    bbf_int_to_double_seq_if bus1 ();
    bbf_int_to_double_seq_if bus8 ();

    assign bus1.in        = in_data;
    assign bus1.in_valid  = in_valid;
    assign bus1.out_ready = out_ready;
    assign bus8.in        = in_data;
    assign bus8.in_valid  = in_valid;
    assign bus8.out_ready = out_ready;

    bbf_int_to_double_seq #(.STEP(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    bbf_int_to_double_seq #(.STEP(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    logic [63:0] obs_out;
    logic        obs_inexact;
    logic        obs_valid;
    logic        obs_ready;

    assign obs_out     = use_step1 ? bus1.out         : bus8.out;
    assign obs_inexact = use_step1 ? bus1.out_inexact : bus8.out_inexact;
    assign obs_valid   = use_step1 ? bus1.out_valid   : bus8.out_valid;
    assign obs_ready   = use_step1 ? bus1.in_ready    : bus8.in_ready;

    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference conversion with plain integer arithmetic: locate the leading
    // one, keep 53 significant bits, round the discarded remainder to
    // nearest-even. Returns {inexact, binary64 bits}.
    function automatic logic [64:0] refConvert(input logic [63:0] x);
        logic        sgn;
        logic [63:0] m;
        logic [63:0] q;
        logic [63:0] rem;
        logic [63:0] half;
        logic        inx;
        int          p;
        int          sh;
        logic [10:0] e;
        sgn = x[63];
        m   = sgn ? (64'd0 - x) : x;
        if (m == 64'd0) return 65'd0;
        p = 63;
        while (m[p] == 1'b0) p--;
        inx = 1'b0;
        if (p > 52) begin
            sh   = p - 52;
            q    = m >> sh;
            rem  = m & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            inx  = (rem != 64'd0);
            if ((rem > half) || ((rem == half) && q[0])) q = q + 64'd1;
            if (q == (64'd1 << 53)) begin
                q = q >> 1;
                p = p + 1;
            end
        end else begin
            q = m << (52 - p);
        end
        e = 11'(1023 + p);
        return {inx, sgn, e, q[51:0]};
    endfunction

    // Edges after the accept edge until out_valid: a zero operand is ready
    // immediately; otherwise each normalization shift costs a cycle, plus
    // one to detect normalization and one to round.
    function automatic int expLatency(input logic [63:0] x, input int step);
        logic [63:0] m;
        int          lz;
        m = x[63] ? (64'd0 - x) : x;
        if (m == 64'd0) return 0;
        lz = 0;
        while (m[63 - lz] == 1'b0) lz++;
        return lz / step + lz % step + 2;
    endfunction

    function automatic logic [63:0] randOperand();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0: begin
                case ($urandom_range(0, 5))
                    0: v = 64'd0;
                    1: v = 64'd1;
                    2: v = 64'hFFFF_FFFF_FFFF_FFFF;
                    3: v = 64'h8000_0000_0000_0000;
                    4: v = 64'h7FFF_FFFF_FFFF_FFFF;
                    default: v = 64'h0020_0000_0000_0001;
                endcase
            end
            1, 2, 3, 4: v = v >> $urandom_range(0, 63);
            5, 6: v = 64'd0 - (v >> $urandom_range(0, 63));
            7: v = {2'b01, v[61:10], 1'b1, 9'd0} >> $urandom_range(0, 2);
            default: ;
        endcase
        return v;
    endfunction

    task automatic doReset();
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One operand through the observed converter, with an optional number
    // of cycles of backpressure in DONE before the result is taken.
    task automatic applyStimulus(input logic [63:0] value, input int hold,
                                 output logic [63:0] res, output logic inx,
                                 output int lat);
        int wait_cnt;
        res = 64'd0;
        inx = 1'b0;
        lat = -1;
        @(negedge clk);
        in_data   = value;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        wait_cnt = 0;
        while (!obs_ready && wait_cnt < 200) begin
            @(negedge clk);
            #1;
            wait_cnt++;
        end
        if (!obs_ready) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        #1;
        wait_cnt = 0;
        while (!obs_valid && wait_cnt < 200) begin
            @(negedge clk);
            #1;
            wait_cnt++;
        end
        if (!obs_valid) begin
            checkOutput("result_timeout", 64'd0, 64'd1);
            return;
        end
        lat = wait_cnt;
        res = obs_out;
        inx = obs_inexact;
        repeat (hold) begin
            @(negedge clk);
            #1;
            checkOutput("hold_out", obs_out, res);
            checkOutput("hold_inexact", 64'(obs_inexact), 64'(inx));
            checkOutput("hold_valid", 64'(obs_valid), 64'd1);
            checkOutput("hold_in_ready", 64'(obs_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checkOutput("no_same_cycle_accept", 64'(obs_ready), 64'd0);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checkOutput("in_ready_back", 64'(obs_ready), 64'd1);
        checkOutput("valid_drop", 64'(obs_valid), 64'd0);
    endtask

    // Random operands with random valid gaps and random out_ready; results
    // must come back in order, none lost, none extra.
    task automatic runRandom(input int n, input string tag);
        logic [64:0] exp_q[$];
        logic [64:0] e;
        int          sent;
        int          got;
        int          cyc;
        bit          pending;
        sent    = 0;
        got     = 0;
        cyc     = 0;
        pending = 1'b0;
        while (got < n && cyc < n * 90 + 1000) begin
            @(negedge clk);
            cyc++;
            if (!pending) begin
                if (sent < n && $urandom_range(0, 3) != 0) begin
                    in_data  = randOperand();
                    in_valid = 1'b1;
                    pending  = 1'b1;
                end else begin
                    in_data  = {$urandom, $urandom};
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && obs_ready) begin
                exp_q.push_back(refConvert(in_data));
                sent++;
                pending = 1'b0;
            end
            if (obs_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput({tag, "_spurious"}, 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput({tag, "_out"}, obs_out, e[63:0]);
                    checkOutput({tag, "_inexact"}, 64'(obs_inexact), 64'(e[64]));
                end
                got++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput({tag, "_count"}, 64'(got), 64'(n));
        checkOutput({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
    endtask

    logic [63:0] dir_val [7] = '{64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000,
                                  64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                                  64'h0020_0000_0000_0001, 64'h0020_0000_0000_0003,
                                  64'h7FFF_FFFF_FFFF_FFFF};
    logic [63:0] dir_exp [7] = '{64'h3FF0_0000_0000_0000, 64'hC3E0_0000_0000_0000,
                                  64'h0000_0000_0000_0000, 64'hBFF0_0000_0000_0000,
                                  64'h4340_0000_0000_0000, 64'h4340_0000_0000_0002,
                                  64'h43E0_0000_0000_0000};
    logic        dir_inx [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        logic [63:0] res;
        logic        inx;
        int          lat;

        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 64'd0;
        use_step1 = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(obs_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(obs_valid), 64'd0);
        checkOutput("rst_out", obs_out, 64'd0);
        checkOutput("rst_inexact", 64'(obs_inexact), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("idle_in_ready", 64'(obs_ready), 64'd1);

        // Directed operands on the STEP=8 converter.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(dir_val[i], (i == 5) ? 10 : 0, res, inx, lat);
            checkOutput($sformatf("dir%0d_out", i), res, dir_exp[i]);
            checkOutput($sformatf("dir%0d_inexact", i), 64'(inx), 64'(dir_inx[i]));
            checkOutput($sformatf("dir%0d_latency", i), 64'(lat), 64'(expLatency(dir_val[i], 8)));
        end

        // STEP=1 converter: full 63-shift normalization, then a short one.
        use_step1 = 1'b1;
        doReset();
        applyStimulus(64'd1, 0, res, inx, lat);
        checkOutput("s1_one_out", res, 64'h3FF0_0000_0000_0000);
        checkOutput("s1_one_latency", 64'(lat), 64'd65);
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 0, res, inx, lat);
        checkOutput("s1_max_out", res, 64'h43E0_0000_0000_0000);
        checkOutput("s1_max_inexact", 64'(inx), 64'd1);
        checkOutput("s1_max_latency", 64'(lat), 64'(expLatency(64'h7FFF_FFFF_FFFF_FFFF, 1)));

        // Reset in the middle of a long normalization; the previous result
        // is still in the output register and must be cleared.
        @(negedge clk);
        in_data  = 64'd1;
        in_valid = 1'b1;
        #1;
        checkOutput("mid_accept_ready", 64'(obs_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_valid_comb", 64'(obs_valid), 64'd0);
        checkOutput("mid_rst_ready_comb", 64'(obs_ready), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("mid_rst_out", obs_out, 64'd0);
        checkOutput("mid_rst_valid", 64'(obs_valid), 64'd0);
        checkOutput("mid_rst_inexact", 64'(obs_inexact), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(obs_ready), 64'd0);
        reset = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", 64'(obs_ready), 64'd1);
        checkOutput("post_rst_out", obs_out, 64'd0);
        applyStimulus(64'h0020_0000_0000_0003, 0, res, inx, lat);
        checkOutput("post_rst_conv_out", res, 64'h4340_0000_0000_0002);
        checkOutput("post_rst_conv_inexact", 64'(inx), 64'd1);
        checkOutput("post_rst_conv_latency", 64'(lat), 64'd12);

        // Randomized traffic on both converters.
        use_step1 = 1'b0;
        doReset();
        runRandom(1500, "rand_s8");
        use_step1 = 1'b1;
        doReset();
        runRandom(150, "rand_s1");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
